// File: rtl/vn_output_collector.sv
// Collects VN value pairs from an edge adder switch into a first-word
// fall-through FIFO, bounded by a programmed count, with a one-cycle done pulse.
module vn_output_collector #(
   parameter int DATA_TYPE = 32,
   parameter int DEPTH     = 8,
   parameter int CNT_W     = 16
) (
   input  logic                   CLK,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [CNT_W-1:0]       i_expected,
   input  logic [2*DATA_TYPE-1:0] i_vn,
   input  logic [1:0]             i_vn_valid,
   output logic                   o_in_ready,
   output logic [DATA_TYPE-1:0]   o_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [CNT_W-1:0]       o_count,
   output logic                   o_done,
   output logic                   o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   state_t               state, state_nxt;
   logic [DATA_TYPE-1:0] mem [DEPTH];
   logic [AW-1:0]        wptr, rptr;
   logic [OW-1:0]        occ;
   logic [CNT_W-1:0]     expected, remain, count_nxt;
   logic [1:0]           wr_n;
   logic [DATA_TYPE-1:0] wr_a, wr_b;
   logic                 drop, pop;

   assign o_in_ready = occ <= OW'(DEPTH - 2);
   assign o_valid    = occ != '0;
   assign o_data     = o_valid ? mem[rptr] : '0;
   assign pop        = o_valid & i_ready;
   assign remain     = expected - o_count;
   assign count_nxt  = o_count + CNT_W'(wr_n);

   // Lane selection: never write past the expected count, shedding lane1 first.
   always_comb begin
      wr_n = 2'd0;
      drop = 1'b0;
      wr_a = i_vn_valid[0] ? i_vn[DATA_TYPE-1:0] : i_vn[2*DATA_TYPE-1:DATA_TYPE];
      wr_b = i_vn[2*DATA_TYPE-1:DATA_TYPE];
      if (state == COLLECT && o_in_ready) begin
         case (i_vn_valid)
            2'b00: ;
            2'b11: begin
               if (remain >= CNT_W'(2)) begin
                  wr_n = 2'd2;
               end else if (remain == CNT_W'(1)) begin
                  wr_n = 2'd1;
                  drop = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end
            default: begin
               if (remain != '0) wr_n = 2'd1;
               else              drop = 1'b1;
            end
         endcase
      end else begin
         drop = |i_vn_valid;
      end
   end

   always_comb begin
      state_nxt = state;
      o_done    = 1'b0;
      case (state)
         IDLE:    if (i_start) state_nxt = (i_expected == '0) ? DRAIN : COLLECT;
         COLLECT: if (count_nxt == expected) state_nxt = DRAIN;
         DRAIN:   if (occ == '0) state_nxt = DONE;
         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         wptr       <= '0;
         rptr       <= '0;
         occ        <= '0;
         expected   <= '0;
         o_count    <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (state == IDLE && i_start) begin
            expected   <= i_expected;
            o_count    <= '0;
            o_overflow <= 1'b0;
         end else begin
            o_count <= count_nxt;
            if (drop) o_overflow <= 1'b1;
         end
         wptr <= wptr + AW'(wr_n);
         rptr <= rptr + AW'(pop);
         occ  <= occ + OW'(wr_n) - OW'(pop);
      end
   end

   // Storage needs no reset: o_data is masked while the FIFO is empty.
   always_ff @(posedge CLK) begin
      if (wr_n != 2'd0) mem[wptr] <= wr_a;
      if (wr_n == 2'd2) mem[wptr + AW'(1)] <= wr_b;
   end

endmodule
